div: RTL
========

# div

Sequential signed divider; the inverse of the team's signed `mult` block. It divides a 2·DATA_WIDTH-bit signed dividend, such as a `mult` product, by a DATA_WIDTH-bit signed divisor. It returns a DATA_WIDTH-bit quotient and remainder, plus overflow and divide-by-zero flags. It uses radix-2 restoring division on magnitudes, one bit per cycle, with a valid/ready input and a one-cycle result strobe.

## Interface
- `DATA_WIDTH`, default 32: operand width; dividend is 2·DATA_WIDTH.
- `clk`  in  1: clock; all logic is on the rising edge.
- `rst_n`  in  1: synchronous, active-low reset.
- `i_valid`  in  1: operands present.
- `o_ready`  out  1: block idle; operands are accepted on an edge where `i_valid && o_ready`.
- `i_a`  in  2·DATA_WIDTH: signed dividend.
- `i_b`  in  DATA_WIDTH: signed divisor.
- `o_valid`  out  1: one-cycle strobe; results below are valid.
- `o_q`  out  DATA_WIDTH: signed quotient, truncated toward zero.
- `o_r`  out  DATA_WIDTH: signed remainder; its sign equals the dividend's sign, or it is zero.
- `o_ovf`  out  1: true quotient does not fit in DATA_WIDTH signed bits.
- `o_dbz`  out  1: divisor was zero.

## Operation
- States and transitions:
  - IDLE → CALC on accept.
  - CALC stays for 2·DATA_WIDTH iterations, then → FIX.
  - FIX → IDLE, unconditionally.
- On accept:
  - Register |i_a| (2W-bit unsigned; −2^(2W−1) is representable) and |i_b| (W-bit unsigned).
  - Register the sign of i_a and the sign of i_a XOR i_b.
  - Register dbz = (i_b == 0).
  - Clear the (W+1)-bit partial remainder; load the iteration counter with 2W−1.
- Each CALC edge:
  - Shift {partial remainder, dividend} left by 1.
  - Trial-subtract |b|. If the result is non-negative, keep it and shift in quotient bit 1; else restore and shift in 0.
  - Counter decrements; the last iteration is at counter 0.
- FIX edge:
  - Apply signs: quotient negated if the XOR sign is set; remainder negated if the dividend sign is set.
  - ovf = 2W-bit signed quotient ∉ [−2^(W−1), 2^(W−1)−1].
  - Register o_q, o_r, o_ovf, o_dbz; assert o_valid.
- Divide-by-zero:
  - Overrides the normal result: o_dbz=1, o_ovf=0, o_q = all ones, o_r = i_a[W−1:0].
  - Same latency as a normal divide.
- Registered results hold until the next FIX. o_valid is 0 in every other cycle.
- i_valid while o_ready=0 is ignored; no queuing.

## Timing
- Reset (rst_n low at an edge, any state, including mid-CALC):
  - State → IDLE, counter → 0, the in-flight operation is discarded.
  - o_valid, o_q, o_r, o_ovf, o_dbz → 0.
  - o_ready = 1 in the first cycle after the reset edge.
- o_ready is decoded from state: 1 in IDLE, 0 otherwise.
- Latency: with accept at edge E0, o_valid is high for exactly one cycle after edge E0 + 2W + 1 (17 cycles for W=8, 65 for W=32).
- Throughput: o_ready rises in the same cycle as o_valid, so a new accept is allowed in that cycle. Back-to-back operations start every 2W+2 cycles.

## Configuration
- Macro: `DIV_SAT_EN`.
- Defined: on overflow, o_q saturates to 2^(W−1)−1 if the true quotient is positive, −2^(W−1) if negative.
- Undefined: on overflow, o_q = low W bits of the true 2W-bit signed quotient, i.e. wrapped.
- o_ovf and o_r are identical in both builds.

## Structure
- Package `div_pkg`:
  - State enum: `DIV_IDLE`, `DIV_CALC`, `DIV_FIX`.
  - `div_lat(W)` function returning 2W+1.
  - Saturation constants derived from W.
- Sub-module `div_step`: one combinational restoring iteration.
  - Inputs: partial remainder, next dividend bit, |b|.
  - Outputs: new partial remainder, quotient bit.
  - Instantiated once inside the sequential `div`.

## Test plan
All cases use W=8.
- Unsigned case: accept a=100, b=7 → after 17 cycles o_valid=1 for one cycle, q=14, r=2, ovf=0, dbz=0.
- Signed cases:
  - a=−100, b=7 → q=−14, r=−2.
  - a=100, b=−7 → q=−14, r=2.
  - a=−100, b=−7 → q=14, r=−2.
- Product inverse: a=16384 (from −128·−128), b=−128 → q=−128, r=0, ovf=0.
- Overflow: a=16384, b=1 → ovf=1. q=127 with `DIV_SAT_EN` defined, q=0x00 without it; r=0 in both.
- Divide-by-zero: a=1234, b=0 → dbz=1, ovf=0, q=0xFF, r=0xD2, after 17 cycles.
- Control boundaries:
  - Hold i_valid high with new operands throughout: exactly one accept per 18 cycles.
  - Assert rst_n low for one edge mid-CALC: o_ready=1 next cycle, no o_valid from the aborted operation, outputs zero.
  - A fresh divide after that reset returns correct results.

Source files
------------

// File: rtl/div_pkg.sv
// Shared state encoding, latency helper and saturation limits for the signed divider.
package div_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_FIX  = 2'd2
  } div_state_e;

  // Cycles from the accepting edge to the edge that raises o_valid.
  function automatic int div_lat(input int w);
    return 2 * w + 1;
  endfunction

  function automatic longint div_sat_max(input int w);
    return (longint'(1) <<< (w - 1)) - 1;
  endfunction

  function automatic longint div_sat_min(input int w);
    return -(longint'(1) <<< (w - 1));
  endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration on magnitudes.
module div_step
  import div_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [W:0]   rem,
  input  logic         din,
  input  logic [W-1:0] babs,
  output logic [W:0]   rem_out,
  output logic         qbit
);

  logic [W+1:0] shifted;
  logic [W+1:0] bext;

  always_comb begin
    shifted = {rem, din};
    bext    = {2'b00, babs};
    qbit    = (shifted >= bext);
    rem_out = qbit ? (W+1)'(shifted - bext) : shifted[W:0];
  end

endmodule

// File: rtl/div.sv
// Sequential signed divider: 2W-bit dividend / W-bit divisor, one quotient bit per cycle.
// Optional build macro DIV_SAT_EN saturates the quotient on overflow instead of wrapping.
module div
  import div_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic [2*DATA_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0]   i_b,
  output logic                    o_valid,
  output logic [DATA_WIDTH-1:0]   o_q,
  output logic [DATA_WIDTH-1:0]   o_r,
  output logic                    o_ovf,
  output logic                    o_dbz
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(2 * W);

  div_state_e     state_reg;
  logic [CW-1:0]  cnt_reg;
  logic [W:0]     rem_reg;
  logic [2*W-1:0] dvd_reg;
  logic [W-1:0]   babs_reg;
  logic [W-1:0]   alow_reg;
  logic           sa_reg;
  logic           sq_reg;
  logic           dbz_reg;

  logic [W:0]     rem_step;
  logic           qbit;
  logic [2*W-1:0] a_abs;
  logic [W-1:0]   b_abs;
  logic [W-1:0]   q_wrap;
  logic [W-1:0]   q_fix;
  logic [W-1:0]   r_fix;
  logic           ovf_pos;
  logic           ovf_neg;
  logic           ovf_w;

  assign o_ready = (state_reg == DIV_IDLE);

  div_step #(.W(W)) u_step (
    .rem     (rem_reg),
    .din     (dvd_reg[2*W-1]),
    .babs    (babs_reg),
    .rem_out (rem_step),
    .qbit    (qbit)
  );

  always_comb begin
    a_abs   = i_a[2*W-1] ? (~i_a + 1'b1) : i_a;
    b_abs   = i_b[W-1] ? (~i_b + 1'b1) : i_b;
    // dvd_reg holds the quotient magnitude once CALC has run; low bits of a
    // negation depend only on low bits, so the wrapped result needs no 2W negate.
    q_wrap  = sq_reg ? (~dvd_reg[W-1:0] + 1'b1) : dvd_reg[W-1:0];
    ovf_pos = |dvd_reg[2*W-1:W-1];
    ovf_neg = (|dvd_reg[2*W-1:W]) | (dvd_reg[W-1] & (|dvd_reg[W-2:0]));
    ovf_w   = sq_reg ? ovf_neg : ovf_pos;
    r_fix   = sa_reg ? (~rem_reg[W-1:0] + 1'b1) : rem_reg[W-1:0];
`ifdef DIV_SAT_EN
    q_fix   = ovf_w ? (sq_reg ? W'(div_sat_min(W)) : W'(div_sat_max(W))) : q_wrap;
`else
    q_fix   = q_wrap;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= DIV_IDLE;
      cnt_reg   <= '0;
      rem_reg   <= '0;
      dvd_reg   <= '0;
      babs_reg  <= '0;
      alow_reg  <= '0;
      sa_reg    <= 1'b0;
      sq_reg    <= 1'b0;
      dbz_reg   <= 1'b0;
      o_valid   <= 1'b0;
      o_q       <= '0;
      o_r       <= '0;
      o_ovf     <= 1'b0;
      o_dbz     <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      case (state_reg)
        DIV_IDLE: begin
          if (i_valid) begin
            dvd_reg   <= a_abs;
            babs_reg  <= b_abs;
            alow_reg  <= i_a[W-1:0];
            sa_reg    <= i_a[2*W-1];
            sq_reg    <= i_a[2*W-1] ^ i_b[W-1];
            dbz_reg   <= (i_b == '0);
            rem_reg   <= '0;
            cnt_reg   <= CW'(2 * W - 1);
            state_reg <= DIV_CALC;
          end
        end
        DIV_CALC: begin
          rem_reg <= rem_step;
          dvd_reg <= {dvd_reg[2*W-2:0], qbit};
          cnt_reg <= cnt_reg - 1'b1;
          if (cnt_reg == '0) state_reg <= DIV_FIX;
        end
        DIV_FIX: begin
          o_valid   <= 1'b1;
          state_reg <= DIV_IDLE;
          if (dbz_reg) begin
            o_q   <= '1;
            o_r   <= alow_reg;
            o_ovf <= 1'b0;
            o_dbz <= 1'b1;
          end else begin
            o_q   <= q_fix;
            o_r   <= r_fix;
            o_ovf <= ovf_w;
            o_dbz <= 1'b0;
          end
        end
        default: state_reg <= DIV_IDLE;
      endcase
    end
  end

endmodule
